// File: rtl/vga_pkg.sv
// Shared colour types, named colours and the RGB888 -> RGB444 reduction
// used by the VGA window reader.
package vga_pkg;

    typedef logic [11:0] rgb12_t;
    typedef logic [23:0] rgb24_t;

    localparam rgb12_t COLOR_BLACK = 12'h000;
    localparam rgb12_t COLOR_WHITE = 12'hFFF;
    localparam rgb12_t COLOR_BLUE  = 12'h00F;

    // Keep the top nibble of each channel.
    function automatic rgb12_t rgb24_to_12(input rgb24_t p);
        return {p[23:20], p[15:12], p[7:4]};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear; aligns the
// window/blank/sync flags with the BRAM read pipeline.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_window_reader.sv
// Maps visible VGA coordinates onto an up-scaled image window held in BRAM,
// keeping colour and sync aligned. Optional border: VGA_WINDOW_BORDER_EN.
module vga_window_reader
    import vga_pkg::*;
#(
    parameter int     IMG_W      = 512,
    parameter int     IMG_H      = 384,
    parameter int     X0         = 0,
    parameter int     Y0         = 0,
    parameter int     SCALE_LOG2 = 0,
    parameter int     BRAM_LAT   = 1,
    parameter int     ADDR_W     = 18,
    parameter rgb12_t BG_COLOR   = COLOR_BLUE
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic [10:0]       hc_visible,
    input  logic [10:0]       vc_visible,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [23:0]       pix_in,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);

    localparam int S     = 1 << SCALE_LOG2;
    localparam int WIN_W = IMG_W * S;
    localparam int WIN_H = IMG_H * S;

    localparam logic [31:0] X_BEG  = 32'(X0);
    localparam logic [31:0] X_END  = 32'(X0 + WIN_W);
    localparam logic [31:0] X_LAST = 32'(X0 + WIN_W - 1);
    localparam logic [31:0] Y_BEG  = 32'(Y0);
    localparam logic [31:0] Y_END  = 32'(Y0 + WIN_H);
    localparam logic [31:0] Y_LAST = 32'(Y0 + WIN_H - 1);

    localparam logic [2:0]        S_LAST   = 3'(S - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    localparam longint PIX_CNT   = longint'(IMG_W) * longint'(IMG_H);
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if (PIX_CNT > ADDR_SPAN) begin : g_chk_size
        $error("vga_window_reader: IMG_W*IMG_H does not fit in ADDR_W bits");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_chk_scale
        $error("vga_window_reader: SCALE_LOG2 must be 0..2");
    end
    if (BRAM_LAT < 1 || BRAM_LAT > 3) begin : g_chk_lat
        $error("vga_window_reader: BRAM_LAT must be 1..3");
    end

    // Stage 0: coordinate decode and window hit
    logic [10:0]       col, row;
    logic [31:0]       col_w, row_w;
    logic              blank, hit, border;
    logic              line_start, last_col, last_row;
    logic [ADDR_W-1:0] col_img, col_cur, row_base;
    logic [2:0]        sx, sx_cur, sy;

    assign col   = hc_visible - 11'd1;
    assign row   = vc_visible - 11'd1;
    assign col_w = {21'd0, col};
    assign row_w = {21'd0, row};

    assign blank = (hc_visible == 11'd0) || (vc_visible == 11'd0);
    assign hit   = !blank
                && (col_w >= X_BEG) && (col_w < X_END)
                && (row_w >= Y_BEG) && (row_w < Y_END);

    // The counter clear at the window's left column takes effect on that
    // same pixel, so the first pixel of each line always reads column 0.
    assign line_start = (col_w == X_BEG);
    assign col_cur    = line_start ? '0 : col_img;
    assign sx_cur     = line_start ? 3'd0 : sx;
    assign last_col   = hit && (col_w == X_LAST);
    assign last_row   = (row_w == Y_LAST);

`ifdef VGA_WINDOW_BORDER_EN
    localparam int XB_L = X0 - 1;
    localparam int XB_R = X0 + WIN_W;
    localparam int YB_T = Y0 - 1;
    localparam int YB_B = Y0 + WIN_H;

    int   col_i, row_i;
    logic in_x_span, in_y_span;

    assign col_i     = int'(col_w);
    assign row_i     = int'(row_w);
    assign in_x_span = (col_i >= XB_L) && (col_i <= XB_R);
    assign in_y_span = (row_i >= YB_T) && (row_i <= YB_B);
    assign border    = !blank && !hit
                    && ((((col_i == XB_L) || (col_i == XB_R)) && in_y_span)
                     || (((row_i == YB_T) || (row_i == YB_B)) && in_x_span));
`else
    assign border = 1'b0;
`endif

    // Stage 1: address generation
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            rd_en    <= 1'b0;
            col_img  <= '0;
            sx       <= 3'd0;
            row_base <= '0;
            sy       <= 3'd0;
        end else begin
            if (hit) begin
                addr  <= row_base + col_cur;
                rd_en <= 1'b1;
                if (sx_cur == S_LAST) begin
                    sx      <= 3'd0;
                    col_img <= col_cur + ONE;
                end else begin
                    sx      <= sx_cur + 3'd1;
                    col_img <= col_cur;
                end
            end else begin
                rd_en <= 1'b0;
                if (line_start) begin
                    col_img <= '0;
                    sx      <= 3'd0;
                end
            end

            // Row stepping is frozen on the final window row so the last
            // address of the frame stays IMG_W*IMG_H-1.
            if (vc_visible == 11'd0) begin
                row_base <= '0;
                sy       <= 3'd0;
            end else if (last_col) begin
                if (sy == S_LAST) begin
                    sy <= 3'd0;
                    if (!last_row) row_base <= row_base + ROW_STEP;
                end else begin
                    sy <= sy + 3'd1;
                end
            end
        end
    end

    // Stages 1..BRAM_LAT+1: flag alignment with the BRAM read
    localparam int DL_W = 5;

    logic [DL_W-1:0] dl_in, dl_out;
    logic            hit_d, blank_d, hs_d, vs_d, border_d;

    assign dl_in = {hit, blank, hs_in, vs_in, border};

    vga_delay_line #(
        .DEPTH(BRAM_LAT + 1),
        .WIDTH(DL_W)
    ) u_align (
        .clk  (clk_vga),
        .rst_n(rst_n),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign {hit_d, blank_d, hs_d, vs_d, border_d} = dl_out;

    // Stage BRAM_LAT+2: output register
    rgb12_t rgb_out;
    logic   hs_out, vs_out;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= COLOR_BLACK;
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
        end else begin
            hs_out <= hs_d;
            vs_out <= vs_d;
            if (blank_d)       rgb_out <= COLOR_BLACK;
            else if (hit_d)    rgb_out <= rgb24_to_12(pix_in);
            else if (border_d) rgb_out <= COLOR_WHITE;
            else               rgb_out <= BG_COLOR;
        end
    end

    assign VGA_HS = hs_out;
    assign VGA_VS = vs_out;
    assign VGA_R  = rgb_out[11:8];
    assign VGA_G  = rgb_out[7:4];
    assign VGA_B  = rgb_out[3:0];

endmodule

// File: tb/tb_vga_window_reader.sv
// Bench for vga_window_reader: three configurations scanned side by side,
// captured per pixel and compared against a hand-computed vector table.
module tb_vga_window_reader;

    localparam int NV   = 20;
    localparam int NH   = 520;
    localparam int NVEC = 29;

`ifdef VGA_WINDOW_BORDER_EN
    localparam logic [11:0] BRD = 12'hFFF;
`else
    localparam logic [11:0] BRD = 12'h00F;
`endif

    logic        clk_vga;
    logic        rst_n;
    logic [10:0] hc, vc;
    logic        hs_in, vs_in;

    logic [17:0] addr0, addr1, addr2;
    logic        rd0, rd1, rd2, hs0, hs1, hs2, vs0, vs1, vs2;
    logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic [23:0] pix0, pix1, pix2, p2a, p2b;

    vga_window_reader u_def (
        .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc), .vc_visible(vc),
        .hs_in(hs_in), .vs_in(vs_in), .pix_in(pix0), .addr(addr0), .rd_en(rd0),
        .VGA_HS(hs0), .VGA_VS(vs0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0)
    );

    vga_window_reader #(
        .IMG_W(4), .IMG_H(2), .X0(2), .Y0(2), .SCALE_LOG2(1)
    ) u_scl (
        .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc), .vc_visible(vc),
        .hs_in(hs_in), .vs_in(vs_in), .pix_in(pix1), .addr(addr1), .rd_en(rd1),
        .VGA_HS(hs1), .VGA_VS(vs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1)
    );

    vga_window_reader #(
        .IMG_W(8), .IMG_H(8), .X0(10), .Y0(10), .BRAM_LAT(3)
    ) u_brd (
        .clk_vga(clk_vga), .rst_n(rst_n), .hc_visible(hc), .vc_visible(vc),
        .hs_in(hs_in), .vs_in(vs_in), .pix_in(pix2), .addr(addr2), .rd_en(rd2),
        .VGA_HS(hs2), .VGA_VS(vs2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    // BRAM model: data chosen so the displayed RGB444 equals addr[11:0].
    function automatic logic [23:0] spread(input logic [17:0] a);
        return {a[11:8], 4'h0, a[7:4], 4'h0, a[3:0], 4'h0};
    endfunction

    always @(posedge clk_vga) begin
        pix0 <= spread(addr0);
        pix1 <= spread(addr1);
        p2a  <= spread(addr2);
        p2b  <= p2a;
        pix2 <= p2b;
    end

    logic [17:0] o_addr [3];
    logic        o_rd [3];
    logic [11:0] o_rgb [3];
    logic        o_hs [3];
    logic        o_vs [3];
    assign o_addr[0] = addr0;  assign o_addr[1] = addr1;  assign o_addr[2] = addr2;
    assign o_rd[0] = rd0;      assign o_rd[1] = rd1;      assign o_rd[2] = rd2;
    assign o_rgb[0] = {r0, g0, b0};
    assign o_rgb[1] = {r1, g1, b1};
    assign o_rgb[2] = {r2, g2, b2};
    assign o_hs[0] = hs0;      assign o_hs[1] = hs1;      assign o_hs[2] = hs2;
    assign o_vs[0] = vs0;      assign o_vs[1] = vs1;      assign o_vs[2] = vs2;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;
    bit cap_en = 1'b0;
    int lat_off [3] = '{2, 2, 4};

    int in_h [65536];
    int in_v [65536];
    bit in_cap [65536];

    logic [17:0] a_cap [3][NV+1][NH+1];
    logic        r_cap [3][NV+1][NH+1];
    logic [11:0] c_cap [3][NV+1][NH+1];
    bit          av    [3][NV+1][NH+1];
    bit          cv    [3][NV+1][NH+1];

    typedef struct {
        int          inst;
        int          h;
        int          v;
        bit          chk_a;
        logic [17:0] a;
        logic        rd;
        logic [11:0] rgb;
    } vec_t;

    vec_t vt [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one pixel, let it clock in, then sample on the falling edge.
    task automatic step(input int h, input int v, input logic hs, input logic vs);
        int k, j;
        hc = 11'(h); vc = 11'(v); hs_in = hs; vs_in = vs;
        n_cyc++;
        k = n_cyc;
        in_h[k] = h; in_v[k] = v; in_cap[k] = cap_en;
        @(posedge clk_vga);
        @(negedge clk_vga);
        for (int i = 0; i < 3; i++) begin
            if (in_cap[k]) begin
                a_cap[i][in_v[k]][in_h[k]] = o_addr[i];
                r_cap[i][in_v[k]][in_h[k]] = o_rd[i];
                av[i][in_v[k]][in_h[k]]    = 1'b1;
            end
            j = k - lat_off[i];
            if (j >= 1 && in_cap[j]) begin
                c_cap[i][in_v[j]][in_h[j]] = o_rgb[i];
                cv[i][in_v[j]][in_h[j]]    = 1'b1;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_u%0d", tag, i),
                {o_addr[i], o_rd[i], o_rgb[i], o_hs[i], o_vs[i]}, 32'd0);
        end
    endtask

    task automatic frame(input int rst_row);
        for (int v = 1; v <= NV; v++) begin
            for (int h = 1; h <= NH; h++) begin
                step(h, v, 1'b0, 1'b0);
                if (v == rst_row && h == 100) begin
                    #2 rst_n = 1'b0;
                    #1 chk_outputs_zero("rst_async");
                end
                if (v == rst_row && h == 102) begin
                    #2 rst_n = 1'b1;
                end
            end
            for (int b = 0; b < 4; b++) step(0, v, 1'b1, 1'b0);
        end
    endtask

    task automatic vblank();
        for (int l = 0; l < 3; l++) begin
            for (int h = 1; h <= 20; h++) step(h, 0, 1'b0, 1'b1);
            for (int b = 0; b < 4; b++) step(0, 0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        // {inst, hc, vc, check addr, addr, rd_en, rgb}
        vt[0]  = '{0,   1,  1, 1'b1,  18'd0,    1'b1, 12'h000};
        vt[1]  = '{0,   2,  1, 1'b1,  18'd1,    1'b1, 12'h001};
        vt[2]  = '{0, 512,  1, 1'b1,  18'd511,  1'b1, 12'h1FF};
        vt[3]  = '{0, 513,  1, 1'b0,  18'd0,    1'b0, BRD};
        vt[4]  = '{0, 520,  1, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[5]  = '{0,   1,  2, 1'b1,  18'd512,  1'b1, 12'h200};
        vt[6]  = '{0, 300,  3, 1'b1,  18'd1323, 1'b1, 12'h52B};
        vt[7]  = '{0,   0,  5, 1'b0,  18'd0,    1'b0, 12'h000};
        vt[8]  = '{0,  10,  0, 1'b0,  18'd0,    1'b0, 12'h000};
        vt[9]  = '{1,   3,  3, 1'b1,  18'd0,    1'b1, 12'h000};
        vt[10] = '{1,   4,  3, 1'b1,  18'd0,    1'b1, 12'h000};
        vt[11] = '{1,   5,  3, 1'b1,  18'd1,    1'b1, 12'h001};
        vt[12] = '{1,  10,  3, 1'b1,  18'd3,    1'b1, 12'h003};
        vt[13] = '{1,   3,  4, 1'b1,  18'd0,    1'b1, 12'h000};
        vt[14] = '{1,   5,  5, 1'b1,  18'd5,    1'b1, 12'h005};
        vt[15] = '{1,  10,  6, 1'b1,  18'd7,    1'b1, 12'h007};
        vt[16] = '{1,  12,  3, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[17] = '{1,   1,  4, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[18] = '{1,   3,  8, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[19] = '{1,   2,  3, 1'b0,  18'd0,    1'b0, BRD};
        vt[20] = '{2,  10, 16, 1'b0,  18'd0,    1'b0, BRD};
        vt[21] = '{2,  11, 16, 1'b1,  18'd40,   1'b1, 12'h028};
        vt[22] = '{2,  18, 18, 1'b1,  18'd63,   1'b1, 12'h03F};
        vt[23] = '{2,  19, 19, 1'b0,  18'd0,    1'b0, BRD};
        vt[24] = '{2,  20, 19, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[25] = '{2,  11, 20, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[26] = '{2,  11, 11, 1'b1,  18'd0,    1'b1, 12'h000};
        vt[27] = '{2,   9, 16, 1'b0,  18'd0,    1'b0, 12'h00F};
        vt[28] = '{2,   0, 16, 1'b0,  18'd0,    1'b0, 12'h000};

        rst_n = 1'b0;
        hc = '0; vc = '0; hs_in = 1'b0; vs_in = 1'b0;
        @(negedge clk_vga);
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
        chk_outputs_zero("rst_hold");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b0);

        frame(0);
        vblank();
        frame(5);
        vblank();
        cap_en = 1'b1;
        frame(0);
        vblank();
        cap_en = 1'b0;

        for (int t = 0; t < NVEC; t++) begin
            int i, h, v;
            string tag;
            i = vt[t].inst; h = vt[t].h; v = vt[t].v;
            tag = $sformatf("vec%0d_u%0d_hc%0d_vc%0d", t, i, h, v);
            if (!av[i][v][h] || !cv[i][v][h]) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: no sample captured, expected rgb %0h", tag, vt[t].rgb);
            end else begin
                chk({tag, "_rgb"}, 32'(c_cap[i][v][h]), 32'(vt[t].rgb));
                chk({tag, "_rd"},  32'(r_cap[i][v][h]), 32'(vt[t].rd));
                if (vt[t].chk_a) chk({tag, "_addr"}, 32'(a_cap[i][v][h]), 32'(vt[t].a));
            end
        end

        // Sync/colour alignment: HS rises at step 1, VS at step 3.
        for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            step(1, 1, 1'b1, (n >= 3));
            chk($sformatf("align_u2_hs_n%0d", n), 32'(hs2), 32'(n >= 5));
            chk($sformatf("align_u2_vs_n%0d", n), 32'(vs2), 32'(n >= 7));
            chk($sformatf("align_u2_rgb_n%0d", n), 32'({r2, g2, b2}),
                (n >= 5) ? 32'h00F : 32'h000);
            chk($sformatf("align_u0_hs_n%0d", n), 32'(hs0), 32'(n >= 3));
            chk($sformatf("align_u0_vs_n%0d", n), 32'(vs0), 32'(n >= 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
